// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches over a req/rdy handshake, sequences EXEC/HALT.
// Optional misaligned next-PC fault enabled by defining IMEM_ALIGN_CHECK_EN.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_next,
  input  logic        stall,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] pc_cur,
  output logic        halted,
  output logic        fault,
  output logic [15:0] retire_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc;
  logic [15:0] w_pc_next;
  logic [15:0] r_instr;
  logic [15:0] w_instr_next;
  logic [15:0] r_retire;
  logic [15:0] w_retire_next;

`ifdef IMEM_ALIGN_CHECK_EN
  logic r_fault;
  logic w_fault_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_instr  <= 16'h0000;
      r_retire <= 16'h0000;
`ifdef IMEM_ALIGN_CHECK_EN
      r_fault  <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_instr  <= w_instr_next;
      r_retire <= w_retire_next;
`ifdef IMEM_ALIGN_CHECK_EN
      r_fault  <= w_fault_next;
`endif
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_instr_next  = r_instr;
    w_retire_next = r_retire;
`ifdef IMEM_ALIGN_CHECK_EN
    w_fault_next  = r_fault;
`endif
    case (r_state)
      S_IDLE: w_state_next = S_FETCH;
      S_FETCH: begin
        if (imem_rdy) begin
          w_instr_next = imem_data;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        // stall freezes everything; otherwise the instruction retires whichever way it leaves
        if (!stall) begin
          w_retire_next = r_retire + 16'd1;
          if (halt) begin
            w_state_next = S_HALTED;
          end
`ifdef IMEM_ALIGN_CHECK_EN
          else if (pc_next[0]) begin
            w_fault_next = 1'b1;
            w_state_next = S_HALTED;
          end
`endif
          else begin
            w_pc_next    = pc_next;
            w_state_next = S_FETCH;
          end
        end
      end
      S_HALTED: w_state_next = S_HALTED;
      default:  w_state_next = S_IDLE;
    endcase
  end

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = (r_state == S_EXEC);
  assign pc_cur      = r_pc;
  assign halted      = (r_state == S_HALTED);
  assign retire_cnt  = r_retire;
`ifdef IMEM_ALIGN_CHECK_EN
  assign fault       = r_fault;
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_fetch_ctrl;

  localparam logic [15:0] RST_PC = 16'h0000;
`ifdef IMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc_next = 16'h0000;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        imem_rdy = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc_cur;
  logic        halted;
  logic        fault;
  logic [15:0] retire_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .pc_next(pc_next), .stall(stall), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid), .pc_cur(pc_cur), .halted(halted),
    .fault(fault), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the core is doing, expressed as "waiting to start / waiting on memory /
  // executing / stopped", tracked via the expected outputs themselves.
  bit          m_started = 0;
  bit          m_starting;
  bit          m_req, m_valid, m_halted, m_fault;
  logic [15:0] m_pc, m_instr, m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_started = 1; m_starting = 1;
      m_req = 0; m_valid = 0; m_halted = 0; m_fault = 0;
      m_pc = RST_PC; m_instr = 16'h0000; m_cnt = 16'h0000;
    end else if (m_started) begin
      if (m_starting) begin
        m_starting = 0;
        m_req = 1;
      end else if (m_req) begin
        if (imem_rdy) begin
          m_instr = imem_data; m_req = 0; m_valid = 1;
        end
      end else if (m_valid && !stall) begin
        m_cnt = m_cnt + 16'd1;
        m_valid = 0;
        if (halt) m_halted = 1;
        else if (ALIGN && pc_next[0]) begin m_halted = 1; m_fault = 1; end
        else begin m_pc = pc_next; m_req = 1; end
      end
    end
  end

  // Single compare process: every cycle after the first reset
  always @(negedge clk) begin
    if (m_started) begin
      check("imem_req",    {15'd0, imem_req},    {15'd0, m_req});
      check("imem_addr",   imem_addr,            m_pc);
      check("pc_cur",      pc_cur,               m_pc);
      check("instr",       instr,                m_instr);
      check("instr_valid", {15'd0, instr_valid}, {15'd0, m_valid});
      check("halted",      {15'd0, halted},      {15'd0, m_halted});
      check("fault",       {15'd0, fault},       {15'd0, m_fault});
      check("retire_cnt",  retire_cnt,           m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // reset
    rst = 1;
    step(); step();
    check("rst_req",   {15'd0, imem_req}, 16'd0);
    check("rst_pc",    pc_cur, 16'h0000);
    check("rst_instr", instr, 16'h0000);
    check("rst_cnt",   retire_cnt, 16'h0000);
    rst = 0;
    check("cyc1_req", {15'd0, imem_req}, 16'd0);
    step();
    check("cyc2_req",  {15'd0, imem_req}, 16'd1);
    check("cyc2_addr", imem_addr, 16'h0000);
    // rdy delayed 3 cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_req",  {15'd0, imem_req}, 16'd1);
      check("wait_addr", imem_addr, 16'h0000);
    end
    imem_rdy = 1; imem_data = 16'hA123;
    step();
    imem_rdy = 0; imem_data = 16'h0000;
    check("exec_instr", instr, 16'hA123);
    check("exec_valid", {15'd0, instr_valid}, 16'd1);
    pc_next = 16'h0040;
    step();
    check("adv_valid", {15'd0, instr_valid}, 16'd0);
    check("adv_req",   {15'd0, imem_req}, 16'd1);
    check("adv_addr",  imem_addr, 16'h0040);
    check("adv_cnt",   retire_cnt, 16'd1);
    // stall with halt pending
    imem_rdy = 1; imem_data = 16'h5A5A;
    step();
    imem_rdy = 0; stall = 1; halt = 1; pc_next = 16'h0100;
    check("st_valid0", {15'd0, instr_valid}, 16'd1);
    step();
    check("st_valid1", {15'd0, instr_valid}, 16'd1);
    step();
    check("st_valid2", {15'd0, instr_valid}, 16'd1);
    check("st_pc",     pc_cur, 16'h0040);
    stall = 0;
    step();
    halt = 0;
    check("hlt_halted", {15'd0, halted}, 16'd1);
    check("hlt_cnt",    retire_cnt, 16'd2);
    check("hlt_pc",     pc_cur, 16'h0040);
    for (int i = 0; i < 12; i++) begin
      imem_rdy = 1'($urandom); stall = 1'($urandom); halt = 1'($urandom);
      step();
      check("hlt_hold_req", {15'd0, imem_req}, 16'd0);
      check("hlt_hold",     {15'd0, halted}, 16'd1);
    end
    imem_rdy = 0; stall = 0; halt = 0;
    rst = 1;
    step();
    rst = 0;
    check("hlt_rst_pc",     pc_cur, RST_PC);
    check("hlt_rst_halted", {15'd0, halted}, 16'd0);
    // rst mid-handshake
    step();
    step();
    check("mid_req", {15'd0, imem_req}, 16'd1);
    rst = 1; imem_rdy = 1; imem_data = 16'hFFFF;
    step();
    rst = 0; imem_rdy = 0;
    check("mid_rst_req",   {15'd0, imem_req}, 16'd0);
    check("mid_rst_instr", instr, 16'h0000);
    // odd next-PC
    step();
    imem_rdy = 1; imem_data = 16'h1111;
    step();
    imem_rdy = 0; pc_next = 16'h0041;
    step();
    if (ALIGN) begin
      check("odd_fault",  {15'd0, fault}, 16'd1);
      check("odd_halted", {15'd0, halted}, 16'd1);
      check("odd_req",    {15'd0, imem_req}, 16'd0);
      check("odd_pc",     pc_cur, 16'h0000);
    end else begin
      check("odd_addr",  imem_addr, 16'h0041);
      check("odd_fault", {15'd0, fault}, 16'd0);
      check("odd_req",   {15'd0, imem_req}, 16'd1);
    end
    rst = 1;
    step();
    rst = 0;
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      imem_rdy  = ($urandom_range(0, 99) < 50);
      imem_data = 16'($urandom);
      stall     = ($urandom_range(0, 99) < 25);
      halt      = ($urandom_range(0, 99) < 4);
      pc_next   = 16'($urandom) & ((($urandom_range(0, 99) < 5)) ? 16'hFFFF : 16'hFFFE);
      rst       = ($urandom_range(0, 99) < 1) || (halted && ($urandom_range(0, 7) == 0));
      step();
    end
    rst = 0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
